// File: rtl/velocidade_pkg.sv
// Shared types and segment constants for the speed readout.
// Segment bit order is {a,b,c,d,e,f,g}, MSB = a, active-high.
package velocidade_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic [0:0] {
    OCIOSO,
    CONVERTE
  } estado_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_TRACO = 7'b0000001;

  localparam seg_t SEG_DIG [0:9] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011   // 9
  };

  // BCD digits needed to hold any VEL_W-bit value, plus one spare above the display so that
  // overflow is simply "some digit above the display is non-zero".
  function automatic int unsigned bcd_digitos(input int unsigned vel_w,
                                              input int unsigned digits);
    int unsigned n;
    n = (vel_w + 2) / 3;
    if (digits > n) n = digits;
    return n + 1;
  endfunction

  function automatic seg_t seg_de_bcd(input logic [3:0] d);
    seg_t s;
    s = SEG_BLANK;
    if (d <= 4'd9) s = SEG_DIG[d];
    return s;
  endfunction

endpackage

// File: rtl/velocidade_display_scan_bcd.sv
// Sequential double-dabble: one shift/add-3 step per cycle, VEL_W steps, then one commit cycle.
// A start while converting restarts with the new value and discards the partial result.
module bin_para_bcd
  import velocidade_pkg::*;
#(
  parameter int unsigned VEL_W  = 4,
  parameter int unsigned DIGITS = 2
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [VEL_W-1:0]                            valor,
  output logic                                        ocupado,
  output logic                                        pronto,
  output logic [4*bcd_digitos(VEL_W, DIGITS)-1:0]     bcd
);

  localparam int unsigned BCD_N = bcd_digitos(VEL_W, DIGITS);
  localparam int unsigned BCD_W = 4 * BCD_N;
  localparam int unsigned CNT_W = $clog2(VEL_W + 1);

  estado_t          estado_q, estado_d;
  logic [VEL_W-1:0] desloc_q, desloc_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, ajustado;
  logic [CNT_W-1:0] passo_q, passo_d;
  logic             ocupado_q, ocupado_d;
  logic             commit;

  always_comb begin
    ajustado = bcd_q;
    for (int i = 0; i < int'(BCD_N); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) ajustado[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    estado_d = estado_q;
    desloc_d = desloc_q;
    bcd_d    = bcd_q;
    passo_d  = passo_q;
    commit   = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (start) begin
          desloc_d = valor;
          bcd_d    = '0;
          passo_d  = '0;
          estado_d = CONVERTE;
        end
      end
      CONVERTE: begin
        if (start) begin
          desloc_d = valor;
          bcd_d    = '0;
          passo_d  = '0;
        end else if (passo_q == CNT_W'(VEL_W)) begin
          commit   = 1'b1;
          estado_d = OCIOSO;
        end else begin
          bcd_d    = {ajustado[BCD_W-2:0], desloc_q[VEL_W-1]};
          desloc_d = desloc_q << 1;
          passo_d  = passo_q + 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // Busy rises the cycle after the load strobe and stays up across restarts.
    ocupado_d = (estado_q == CONVERTE) && !commit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      desloc_q  <= '0;
      bcd_q     <= '0;
      passo_q   <= '0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      desloc_q  <= desloc_d;
      bcd_q     <= bcd_d;
      passo_q   <= passo_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign ocupado = ocupado_q;
  assign pronto  = commit;
  assign bcd     = bcd_q;

endmodule

// File: rtl/velocidade_display_scan.sv
// Multiplexed seven-segment speed display: BCD conversion, blanking, overflow dash and scan.
// Optional VEL_BLINK_EN: blink the digit selects for BLINK_ROUNDS rounds after a changed value.
module velocidade_display_scan
  import velocidade_pkg::*;
#(
  parameter int unsigned VEL_W        = 4,
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned BLINK_ROUNDS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [VEL_W-1:0]  velocidade,
  input  logic              vel_valida,
  output logic              ocupado,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] anodo
);

  localparam int unsigned BCD_N = bcd_digitos(VEL_W, DIGITS);
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIGITS-1:0] UM         = DIGITS'(1);
  localparam logic [DIGITS-1:0] ANODO_RST  = (ACTIVE_LOW != 0) ? ~UM : UM;
  localparam seg_t              SEG_RST    = (ACTIVE_LOW != 0) ? ~SEG_DIG[0] : SEG_DIG[0];

  logic               pronto;
  logic [4*BCD_N-1:0] bcd;

  bin_para_bcd #(
    .VEL_W  (VEL_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clock   (clock),
    .reset   (reset),
    .start   (vel_valida),
    .valor   (velocidade),
    .ocupado (ocupado),
    .pronto  (pronto),
    .bcd     (bcd)
  );

  seg_t              dig_q [DIGITS];
  seg_t              dig_d [DIGITS];
  seg_t              novo  [DIGITS];
  logic              overflow;
  logic              acima;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fim_pre;
  logic              apagar;
  seg_t              seg_d, seg_q;
  logic [DIGITS-1:0] anodo_d, anodo_q;

  // Commit patterns: dash on overflow, otherwise blank digits above the top non-zero one.
  always_comb begin
    overflow = |bcd[4*BCD_N-1:4*DIGITS];
    acima    = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (overflow) begin
        novo[i] = SEG_TRACO;
      end else if (i == 0 || acima || bcd[4*i +: 4] != 4'd0) begin
        novo[i] = seg_de_bcd(bcd[4*i +: 4]);
      end else begin
        novo[i] = SEG_BLANK;
      end
      acima = acima | (bcd[4*i +: 4] != 4'd0);
    end
    dig_d = dig_q;
    if (pronto) dig_d = novo;
  end

  always_comb begin
    fim_pre = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d   = fim_pre ? '0 : pre_q + 1'b1;
    idx_d   = idx_q;
    if (fim_pre) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    // Outputs are built from next-state values so seg and anodo switch together with the index.
    seg_d   = dig_d[idx_d];
    anodo_d = apagar ? '0 : (UM << idx_d);
  end

`ifdef VEL_BLINK_EN
  localparam int unsigned ROD_W = $clog2(BLINK_ROUNDS + 1);

  logic [ROD_W-1:0]   rodada_q, rodada_d;
  logic [4*BCD_N-1:0] ultimo_q;
  logic               fim_rodada;

  assign fim_rodada = fim_pre && (idx_q == IDX_W'(DIGITS - 1));

  // Round counter saturates at BLINK_ROUNDS, which means "not blinking".
  always_comb begin
    rodada_d = rodada_q;
    if (pronto && (bcd != ultimo_q)) begin
      rodada_d = '0;
    end else if (fim_rodada && (rodada_q < ROD_W'(BLINK_ROUNDS))) begin
      rodada_d = rodada_q + 1'b1;
    end
    apagar = (rodada_d < ROD_W'(BLINK_ROUNDS)) && rodada_d[0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rodada_q <= ROD_W'(BLINK_ROUNDS);
      ultimo_q <= '0;
    end else begin
      rodada_q <= rodada_d;
      if (pronto) ultimo_q <= bcd;
    end
  end
`else
  assign apagar = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DIGITS); i++) dig_q[i] <= (i == 0) ? SEG_DIG[0] : SEG_BLANK;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_RST;
      anodo_q <= ANODO_RST;
    end else begin
      dig_q   <= dig_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= (ACTIVE_LOW != 0) ? ~seg_d : seg_d;
      anodo_q <= (ACTIVE_LOW != 0) ? ~anodo_d : anodo_d;
    end
  end

  assign seg   = seg_q;
  assign anodo = anodo_q;

endmodule

// File: tb/tb_velocidade_display_scan.sv
// Bench: two instances (2-digit active-low, 1-digit active-high) share one stimulus stream;
// expected digit patterns are queued at load time and popped when the display is inspected.
module tb_velocidade_display_scan;

  localparam int SD_A = 4;
  localparam int SD_B = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] velocidade = 4'd0;
  logic       vel_valida = 1'b0;

  logic       ocupado, ocupado_b;
  logic [6:0] seg, seg_b;
  logic [1:0] anodo;
  logic [0:0] anodo_b;

  int erros  = 0;
  int checks = 0;

  logic [6:0] esp_a [$];
  logic [6:0] esp_b [$];

  velocidade_display_scan #(
    .VEL_W (4), .DIGITS (2), .SCAN_DIV (SD_A), .ACTIVE_LOW (1), .BLINK_ROUNDS (8)
  ) dut (
    .clock (clock), .reset (reset), .velocidade (velocidade), .vel_valida (vel_valida),
    .ocupado (ocupado), .seg (seg), .anodo (anodo)
  );

  velocidade_display_scan #(
    .VEL_W (4), .DIGITS (1), .SCAN_DIV (SD_B), .ACTIVE_LOW (0), .BLINK_ROUNDS (8)
  ) dut_b (
    .clock (clock), .reset (reset), .velocidade (velocidade), .vel_valida (vel_valida),
    .ocupado (ocupado_b), .seg (seg_b), .anodo (anodo_b)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] tabela(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  // Active-high pattern for decimal position pos of value v on an nd-digit display.
  function automatic logic [6:0] esperado(input int v, input int nd, input int pos);
    int lim, p;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    p = 1;
    for (int k = 0; k < pos; k++) p = p * 10;
    if (v >= lim) return 7'b0000001;
    if (pos > 0 && v < p) return 7'b0000000;
    return tabela((v / p) % 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      erros++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulso(input int v);
    @(negedge clock);
    velocidade = 4'(v);
    vel_valida = 1'b1;
    @(negedge clock);
    vel_valida = 1'b0;
  endtask

  // Counts busy cycles after the load edge until busy drops.
  task automatic esperar_fim(input int n);
    int cnt;
    cnt = 0;
    @(negedge clock);
    for (int t = 0; t < 30 && ocupado; t++) begin
      cnt++;
      @(negedge clock);
    end
    check("ciclos ocupado", cnt, n);
    check("ocupado b apos fim", ocupado_b, 1'b0);
  endtask

  task automatic ver();
    logic [6:0] e, ne;
    logic [1:0] an;
    bit achou;
    for (int d = 0; d < 2; d++) begin
      e     = esp_a.pop_front();
      ne    = ~e;
      an    = 2'b01 << d;
      an    = ~an;
      achou = 1'b0;
      for (int t = 0; t < 40 && !achou; t++) begin
        if (anodo === an) achou = 1'b1;
        else @(negedge clock);
      end
      check($sformatf("anodo digito %0d", d), achou, 1'b1);
      check($sformatf("seg digito %0d", d), seg, ne);
    end
    e = esp_b.pop_front();
    check("seg dut b", seg_b, e);
  endtask

  task automatic carregar(input int v);
    esp_a.push_back(esperado(v, 2, 0));
    esp_a.push_back(esperado(v, 2, 1));
    esp_b.push_back(esperado(v, 1, 0));
    pulso(v);
    check("ocupado na amostra", ocupado, 1'b0);
    esperar_fim(4);
    ver();
  endtask

  task automatic dwell(input logic [1:0] an, input string tag);
    int cnt;
    cnt = 0;
    for (int t = 0; t < 20 && anodo !== an; t++) @(negedge clock);
    while (anodo === an && cnt < 20) begin
      cnt++;
      @(negedge clock);
    end
    check(tag, cnt, SD_A);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset seg", seg, 7'b0000001);
    check("reset anodo", anodo, 2'b10);
    check("reset ocupado", ocupado, 1'b0);
    check("reset seg b", seg_b, 7'b1111110);
    check("reset anodo b", anodo_b, 1'b1);
    reset = 1'b0;

    dwell(2'b01, "dwell digito 1");
    dwell(2'b10, "dwell digito 0");

    carregar(7);
    carregar(12);
    carregar(10);
    carregar(9);
    carregar(0);
    carregar(15);
    carregar(9);

    // Restart mid-conversion: 12 is discarded, only 3 reaches the display.
    pulso(12);
    @(negedge clock);
    check("ocupado durante conversao", ocupado, 1'b1);
    check("display inalterado", seg_b, tabela(9));
    esp_a.push_back(esperado(3, 2, 0));
    esp_a.push_back(esperado(3, 2, 1));
    esp_b.push_back(esperado(3, 1, 0));
    pulso(3);
    check("ocupado no reinicio", ocupado, 1'b1);
    esperar_fim(4);
    ver();

    // Reset during conversion: nothing commits, display returns to "0".
    pulso(8);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset conv ocupado", ocupado, 1'b0);
    check("reset conv seg", seg, 7'b0000001);
    check("reset conv anodo", anodo, 2'b10);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("sem commit ocupado", ocupado, 1'b0);
    esp_a.push_back(esperado(0, 2, 0));
    esp_a.push_back(esperado(0, 2, 1));
    esp_b.push_back(esperado(0, 1, 0));
    ver();

`ifdef VEL_BLINK_EN
    begin
      int apagados;
      carregar(5);
      pulso(9);
      esperar_fim(4);
      apagados = 0;
      for (int t = 0; t < 12 * 2 * SD_A; t++) begin
        if (anodo === 2'b11) apagados++;
        @(negedge clock);
      end
      check("ciclos apagados", apagados, 4 * 2 * SD_A);
      pulso(9);
      esperar_fim(4);
      apagados = 0;
      for (int t = 0; t < 10 * 2 * SD_A; t++) begin
        if (anodo === 2'b11) apagados++;
        @(negedge clock);
      end
      check("sem pisca valor igual", apagados, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
